mlp_stream_loader: RTL
======================

MLP_STREAM_LOADER -- requirements
Module: mlp_stream_loader

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, stream word width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset; one clock, synchronous, active-low.
REQ-004 SHALL have port mode  input  1  0:MLP0 (64-dim), 1:MLP3 (128-dim); latched on start.
REQ-005 SHALL have port ready  input  1  start pulse from host.
REQ-006 SHALL have port data_in  input  DATA_SIZE  packed word, byte0 in [7:0].
REQ-007 SHALL have port ifmap_we / ifmap_addr[4:0] / ifmap_wdata[31:0]  output  ifmap buffer write port.
REQ-008 SHALL have port w_we / w_addr[11:0] / w_wdata[31:0]  output  weight buffer write port.
REQ-009 SHALL have port b_we / b_addr[4:0] / b_wdata[31:0]  output  bias buffer write port.
REQ-010 SHALL have port load_done  output  1  one-cycle pulse, all words written.
REQ-011 SHALL have port compute_done  input  1  core finished; result buffer valid.
REQ-012 SHALL have port res_raddr[6:0] output; res_rdata[7:0] input  result buffer read, 1-cycle latency.
REQ-013 SHALL have port valid  output  1  ofmap carries a result byte.
REQ-014 SHALL have port ofmap  output  DATA_SIZE  result byte in [7:0], upper bits zero.
REQ-015 SHALL have port done  output  1  one-cycle pulse after last result byte.

Function
REQ-016 SHALL implement states IDLE, LD_IFMAP, LD_W, LD_B, WAIT_C, OUT.
REQ-017 IDLE: ready sampled 1 -> latch mode, clear word counter, go LD_IFMAP.
REQ-018 SHALL capture one data_in word on every cycle after the ready cycle, no gaps, no backpressure.
REQ-019 Word counts: ifmap 16/32, weight 1024/4096, bias 16/32 (mode 0/1); totals 1056/4160.
REQ-020 Each captured word SHALL be written to its buffer in the capture cycle: *_we=1, *_wdata=data_in, *_addr=word index within its phase (0-based).
REQ-021 Phase transitions SHALL occur on the last word of each phase; the next cycle's word goes to the next buffer.
REQ-022 load_done SHALL pulse the cycle after the last bias word; state goes WAIT_C.
REQ-023 WAIT_C: compute_done sampled 1 -> OUT, res_raddr=0.
REQ-024 OUT: res_raddr increments each cycle; valid=1 and ofmap={24'b0,res_rdata} one cycle after each address, N=64/128 contiguous valid cycles.
REQ-025 done SHALL pulse the cycle after the final valid; state returns IDLE; valid=0.
REQ-026 ready outside IDLE SHALL be ignored; compute_done outside WAIT_C SHALL be ignored.
REQ-027 ready and compute_done asserted together in IDLE: only ready acts.
REQ-028 Counters SHALL not wrap; terminal counts are exact per latched mode; mode changes after start have no effect.

Reset
REQ-029 rst=0 at a rising edge SHALL force IDLE, counters 0, all *_we=0, all addresses 0, valid=0, ofmap=0, load_done=0, done=0, regardless of state.
REQ-030 Reset mid-load or mid-output SHALL abandon the transfer; no further writes or valid until a new ready.

Configuration
REQ-031 Macro MLP_LOADER_CHECKSUM_EN defined: extra output checksum[31:0] = modulo-2^32 sum of all words captured since start, cleared on start/reset, stable from load_done until next start.
REQ-032 Macro undefined: no checksum port, no adder logic; all other behaviour identical.

Verification
REQ-033 mode=0, ready pulse, 1056 words 0,1,2...: ifmap addr 0..15, w addr 0..1023, b addr 0..15 get matching data; load_done 1 cycle after word 1055.
REQ-034 mode=1, 4160 words: w_addr reaches 4095, b_addr 31; load_done once; no write after it.
REQ-035 After load, compute_done pulse, res buffer[i]=i: 64 consecutive valid cycles with ofmap=0..63, done next cycle.
REQ-036 rst=0 at word 500 of mode-1 load: next cycle all outputs 0, IDLE; new mode-0 ready completes normally.
REQ-037 ready pulses during LD_W and OUT, compute_done during LD_IFMAP: no state/address disturbance.
REQ-038 With MLP_LOADER_CHECKSUM_EN, mode 0, all words 32'h0000_0001: checksum=1056 at load_done.

Source files
------------

// File: rtl/mlp_stream_loader.sv
// Streams ifmap, weight and bias words into their buffers, then drains the result buffer.
// Optional feature: define MLP_LOADER_CHECKSUM_EN to add a running checksum output.
module mlp_stream_loader #(
    parameter int unsigned DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 ready,
    input  logic [DATA_SIZE-1:0] data_in,
    output logic                 ifmap_we,
    output logic [4:0]           ifmap_addr,
    output logic [31:0]          ifmap_wdata,
    output logic                 w_we,
    output logic [11:0]          w_addr,
    output logic [31:0]          w_wdata,
    output logic                 b_we,
    output logic [4:0]           b_addr,
    output logic [31:0]          b_wdata,
    output logic                 load_done,
    input  logic                 compute_done,
    output logic [6:0]           res_raddr,
    input  logic [7:0]           res_rdata,
    output logic                 valid,
    output logic [DATA_SIZE-1:0] ofmap,
    output logic                 done
`ifdef MLP_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]          checksum
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StLdIfmap,
        StLdW,
        StLdB,
        StWaitC,
        StOut
    } state_e;

    state_e      state_q, state_d;
    logic        mode_q, mode_d;
    logic [11:0] cnt_q, cnt_d;
    logic        load_done_q, load_done_d;
    logic        valid_q, valid_d;
    logic        vlast_q, vlast_d;
    logic        done_q, done_d;

    logic [11:0] small_last;
    logic [11:0] w_last;
    logic [11:0] out_last;
    logic [31:0] word;

    assign word       = 32'(data_in);
    assign small_last = mode_q ? 12'd31 : 12'd15;
    assign w_last     = mode_q ? 12'd4095 : 12'd1023;
    assign out_last   = mode_q ? 12'd127 : 12'd63;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        load_done_d = 1'b0;
        // Read data trails the address by one cycle, so valid/last/done are a delay line.
        valid_d     = (state_q == StOut);
        vlast_d     = (state_q == StOut) && (cnt_q == out_last);
        done_d      = vlast_q;
        unique case (state_q)
            StIdle: begin
                if (ready) begin
                    mode_d  = mode;
                    cnt_d   = '0;
                    state_d = StLdIfmap;
                end
            end
            StLdIfmap: begin
                if (cnt_q == small_last) begin
                    cnt_d   = '0;
                    state_d = StLdW;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            StLdW: begin
                if (cnt_q == w_last) begin
                    cnt_d   = '0;
                    state_d = StLdB;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            StLdB: begin
                if (cnt_q == small_last) begin
                    cnt_d       = '0;
                    load_done_d = 1'b1;
                    state_d     = StWaitC;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            StWaitC: begin
                if (compute_done) begin
                    cnt_d   = '0;
                    state_d = StOut;
                end
            end
            StOut: begin
                if (cnt_q == out_last) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            load_done_q <= 1'b0;
            valid_q     <= 1'b0;
            vlast_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            load_done_q <= load_done_d;
            valid_q     <= valid_d;
            vlast_q     <= vlast_d;
            done_q      <= done_d;
        end
    end

    // Write ports are gated to zero when idle so nothing leaks out between phases.
    always_comb begin
        ifmap_we    = (state_q == StLdIfmap);
        w_we        = (state_q == StLdW);
        b_we        = (state_q == StLdB);
        ifmap_addr  = ifmap_we ? cnt_q[4:0] : 5'd0;
        w_addr      = w_we ? cnt_q : 12'd0;
        b_addr      = b_we ? cnt_q[4:0] : 5'd0;
        ifmap_wdata = ifmap_we ? word : 32'd0;
        w_wdata     = w_we ? word : 32'd0;
        b_wdata     = b_we ? word : 32'd0;
        res_raddr   = (state_q == StOut) ? cnt_q[6:0] : 7'd0;
        valid       = valid_q;
        ofmap       = valid_q ? DATA_SIZE'(res_rdata) : '0;
        load_done   = load_done_q;
        done        = done_q;
    end

`ifdef MLP_LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (state_q == StIdle && ready) begin
            sum_d = '0;
        end else if (state_q == StLdIfmap || state_q == StLdW || state_q == StLdB) begin
            sum_d = sum_q + word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`endif

endmodule
